// File: rtl/cdb_pkg.sv
// Shared definitions for the common data bus: requester indices, arbiter defaults, bus widths.
package cdb_pkg;

  localparam int unsigned NUM_REQ = 5;

  localparam int unsigned REQ_MULT   = 0;
  localparam int unsigned REQ_LOAD   = 1;
  localparam int unsigned REQ_BRANCH = 2;
  localparam int unsigned REQ_ALU    = 3;
  localparam int unsigned REQ_STORE  = 4;

  localparam int unsigned STARVE_LIMIT_DEF = 4;
  localparam int unsigned WAIT_W_DEF       = 3;
  localparam int unsigned RR_W             = 3;

  localparam int unsigned CDB_W_WIDE   = 133;
  localparam int unsigned CDB_W_MID    = 101;
  localparam int unsigned CDB_W_NARROW = 69;

  // Position k of a circular scan that starts at base (base < NUM_REQ).
  function automatic logic [RR_W-1:0] circ_idx(input logic [RR_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return RR_W'(s);
  endfunction

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] idx);
    if (32'(idx) >= NUM_REQ - 1) return '0;
    return idx + RR_W'(1);
  endfunction

endpackage

// File: rtl/cdb_wait_ctr.sv
// Per-requester saturating wait counter with a registered starved flag.
module cdb_wait_ctr
  import cdb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned WAIT_W       = WAIT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic grant,
  input  logic stall,
  output logic starved
);

  localparam logic [WAIT_W-1:0] Limit = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              starved_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || grant) begin
      cnt_d = '0;
    end else if (!stall && (cnt_q < Limit)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  // Flag follows the next count so promotion is visible the cycle the limit is reached.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      starved_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      starved_q <= (cnt_d >= Limit);
    end
  end

  assign starved = starved_q;

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: fixed priority (mult > load > branch > alu > store) with round-robin service
// of requesters promoted by their wait counters.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned WAIT_W       = WAIT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               stall,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] starved,
  output logic [RR_W-1:0]    rr_ptr
);

  logic [RR_W-1:0] rr_q, rr_d;
  logic [RR_W-1:0] scan_idx;
  logic [RR_W-1:0] win_idx;
  logic            starve_hit;
  logic            fixed_hit;

  always_comb begin
    grant      = '0;
    scan_idx   = '0;
    win_idx    = rr_q;
    starve_hit = 1'b0;
    fixed_hit  = 1'b0;
    if (!rst && !stall) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = circ_idx(rr_q, k);
        if (!starve_hit && starved[scan_idx] && req[scan_idx]) begin
          grant[scan_idx] = 1'b1;
          win_idx         = scan_idx;
          starve_hit      = 1'b1;
        end
      end
      if (!starve_hit) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!fixed_hit && req[i]) begin
            grant[i]  = 1'b1;
            fixed_hit = 1'b1;
          end
        end
      end
    end
  end

  assign rr_d = starve_hit ? rr_next(win_idx) : rr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_wait
    cdb_wait_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT),
      .WAIT_W      (WAIT_W)
    ) u_wait_ctr (
      .clk    (clk),
      .rst    (rst),
      .req    (req[g]),
      .grant  (grant[g]),
      .stall  (stall),
      .starved(starved[g])
    );
  end

  assign grant_valid = |grant;
  assign rr_ptr      = rr_q;

  a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
  a_subset : assert property (@(posedge clk) disable iff (rst) ((grant & ~req) == '0));
  a_stall  : assert property (@(posedge clk) disable iff (rst) (stall |-> (grant == '0)));

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: directed scenarios plus randomized sticky requests.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N     = 5;
  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall;
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic         grant_valid;
  logic [N-1:0] starved;
  logic [2:0]   rr_ptr;

  cdb_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .WAIT_W      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .stall      (stall),
    .grant      (grant),
    .grant_valid(grant_valid),
    .starved    (starved),
    .rr_ptr     (rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] grant;
    logic         gv;
    logic [N-1:0] starved;
    logic [2:0]   rr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference state: how long each source has been waiting, and where the rotation resumes.
  int       m_wait[N];
  int       m_rr;
  bit [N-1:0] last_g;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit [N-1:0] model_grant(input bit [N-1:0] r, input bit s, input bit rs);
    bit [N-1:0] g;
    g = '0;
    if (rs || s) return g;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr + k) % N;
      if (m_wait[i] >= LIMIT && r[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic cycle(input bit rs, input bit [N-1:0] r, input bit s);
    exp_t       e;
    bit [N-1:0] g;
    @(negedge clk);
    rst   = rs;
    req   = r;
    stall = s;
    g = model_grant(r, s, rs);
    e.grant = g;
    e.gv    = |g;
    for (int i = 0; i < N; i++) e.starved[i] = (m_wait[i] >= LIMIT);
    e.rr = 3'(m_rr);
    sb.push_back(e);
    last_g = g;
    @(posedge clk);
    if (rs) begin
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      m_rr = 0;
    end else begin
      for (int i = 0; i < N; i++) if (g[i] && e.starved[i]) m_rr = (i + 1) % N;
      for (int i = 0; i < N; i++) begin
        if (!r[i] || g[i]) m_wait[i] = 0;
        else if (!s && m_wait[i] < LIMIT) m_wait[i] = m_wait[i] + 1;
      end
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest pending expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        cmp("grant", 32'(grant), 32'(e.grant));
        cmp("grant_valid", 32'(grant_valid), 32'(e.gv));
        cmp("starved", 32'(starved), 32'(e.starved));
        cmp("rr_ptr", 32'(rr_ptr), 32'(e.rr));
      end
    end
  end

  initial begin : driver
    bit [N-1:0] pend;
    bit         stl;
    bit         rs;
    rst   = 1'b1;
    req   = '0;
    stall = 1'b0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
    m_rr   = 0;
    last_g = '0;
    repeat (2) @(posedge clk);

    // Reset with all requests up, then release.
    repeat (2) cycle(1'b1, 5'b11111, 1'b0);
    cycle(1'b0, 5'b11111, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    // Plain fixed priority.
    cycle(1'b0, 5'b11110, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    // Mult and alu held: alu promoted after four losses.
    repeat (7) cycle(1'b0, 5'b01001, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    // Everyone held: starved sources rotate.
    repeat (10) cycle(1'b0, 5'b11111, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    // Stall suppresses grants and freezes waiting.
    repeat (6) cycle(1'b0, 5'b01000, 1'b1);
    cycle(1'b0, 5'b01000, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    // Store drops its request before being served.
    repeat (3) cycle(1'b0, 5'b10001, 1'b0);
    cycle(1'b0, 5'b00001, 1'b0);
    repeat (6) cycle(1'b0, 5'b10001, 1'b0);
    cycle(1'b0, 5'b00000, 1'b0);
    // Reset in the middle of rotation.
    repeat (6) cycle(1'b0, 5'b11111, 1'b0);
    cycle(1'b1, 5'b11111, 1'b0);
    repeat (2) cycle(1'b0, 5'b11111, 1'b0);

    // Random sticky requests: held until granted, occasionally dropped.
    pend = '0;
    repeat (800) begin
      pend = pend & ~last_g;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom_range(0, 2) == 0)) pend[i] = 1'b1;
        else if (pend[i] && ($urandom_range(0, 19) == 0)) pend[i] = 1'b0;
      end
      stl = ($urandom_range(0, 7) == 0);
      rs  = ($urandom_range(0, 99) == 0);
      cycle(rs, pend, stl);
    end
    repeat (2) cycle(1'b0, 5'b00000, 1'b0);

    @(negedge clk);
    #4;
    if (sb.size() != 0) cmp("drain", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
